// File: rtl/sprite_drawer_if.sv
// ---------------------------------------------------------------------------
// sprite_drawer_if
// Bundles the sprite draw command handshake, pattern ROM port and line-buffer
// write port of the sprite drawer.
//   master : scanner/ROM/line-buffer side (drives commands and rom_data)
//   slave  : sprite_drawer side (drives draw_done, rom_addr, lb_*)
// Signals:
//   start_row  new-scanline pulse, aborts any draw in progress
//   draw_req   single-cycle command strobe
//   col_base   screen column of sprite pixel 0
//   flip       horizontal mirror
//   frame_id   pattern frame
//   row_off    row within the sprite
//   draw_done  1 = idle, 0 = busy
//   rom_addr   pattern ROM address {frame_id, row_off, word}
//   rom_data   pattern ROM word (4 pixels), valid one cycle after rom_addr
//   lb_we      line-buffer write enable
//   lb_addr    line-buffer column
//   lb_data    colour index to write
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface sprite_drawer_if;
  logic        start_row;
  logic        draw_req;
  logic [9:0]  col_base;
  logic        flip;
  logic [7:0]  frame_id;
  logic [3:0]  row_off;
  logic        draw_done;
  logic [13:0] rom_addr;
  logic [31:0] rom_data;
  logic        lb_we;
  logic [9:0]  lb_addr;
  logic [7:0]  lb_data;

  modport master (
    output start_row, draw_req, col_base, flip, frame_id, row_off, rom_data,
    input  draw_done, rom_addr, lb_we, lb_addr, lb_data
  );

  modport slave (
    input  start_row, draw_req, col_base, flip, frame_id, row_off, rom_data,
    output draw_done, rom_addr, lb_we, lb_addr, lb_data
  );
endinterface

// File: rtl/sprite_drawer.sv
// ---------------------------------------------------------------------------
// sprite_drawer
// Responder end of the sprite draw handshake. Accepts one sprite-row draw
// command, fetches the 16-pixel row from the pattern ROM as four 32-bit words
// (4 pixels each, pixel 0 in the low byte) and writes the non-transparent
// pixels (colour index != 0) into the scanline line buffer, optionally
// mirrored.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   bus    sprite_drawer_if.slave (command handshake, ROM port, line buffer)
//
// Per word: FETCH (address out) -> WAIT (ROM word captured) -> WRITE x4.
// A command therefore occupies 24 busy cycles after the request cycle.
//
// Build option:
//   SPRITE_CLIP_EN  defined: writes to columns >= LINE_W are suppressed.
//                   undefined: no clipping, lb_addr wraps modulo 1024.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module sprite_drawer #(
  parameter int SPRITE_W  = 16,
  parameter int NUM_FRAME = 256,
  parameter int LINE_W    = 640,
  parameter int ROM_AW    = 14
) (
  input logic            clk,
  input logic            reset,
  sprite_drawer_if.slave bus
);

  localparam int FRAME_W = $clog2(NUM_FRAME);

`ifdef SPRITE_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          w_q, w_d;
  logic [1:0]          k_q, k_d;

  logic [9:0]          col_q;
  logic                flip_q;
  logic [FRAME_W-1:0]  frame_q;
  logic [3:0]          row_q;

  logic [31:0]         word_p1;
  logic [9:0]          lb_addr_q;
  logic [7:0]          lb_data_q;

  logic                accept;
  logic [3:0]          pix_idx;
  logic [7:0]          pix_data;
  logic [10:0]         dest;
  logic                wr_ok;
  logic [ROM_AW-1:0]   rom_addr_w;

  // Destination column of pixel p, kept 11 bits wide so columns past 1023
  // are still visible to the clip comparison.
  function automatic logic [10:0] dest_col(input logic [9:0] base,
                                           input logic       mirror,
                                           input logic [3:0] p);
    logic [3:0] ofs;
    ofs = mirror ? (4'(SPRITE_W - 1) - p) : p;
    return {1'b0, base} + {7'd0, ofs};
  endfunction

  // Colour index 0 is transparent; with clipping, columns off the right
  // edge of the visible line are dropped too.
  function automatic logic pix_visible(input logic [7:0]  data,
                                       input logic [10:0] d);
    return (data != 8'd0) && (!CLIP_EN || (d < 11'(LINE_W)));
  endfunction

  // A request is taken only from IDLE, and a same-cycle start_row wins.
  assign accept = (state_q == IDLE) && bus.draw_req && !bus.start_row;

  // Combinational so draw_done drops in the very cycle the request is seen.
  assign bus.draw_done = (state_q == IDLE) && !(bus.draw_req && !bus.start_row);

  // ---- stage 0: ROM address from latched command and word counter ----
  assign rom_addr_w   = {frame_q, row_q, w_q};
  assign bus.rom_addr = rom_addr_w;

  // ---- stage 2: pixel select, destination, write decision ----
  assign pix_idx  = {w_q, k_q};
  assign pix_data = word_p1[8*k_q +: 8];
  assign dest     = dest_col(col_q, flip_q, pix_idx);
  assign wr_ok    = pix_visible(pix_data, dest);

  assign bus.lb_we   = (state_q == WRITE) && !bus.start_row && wr_ok;
  assign bus.lb_addr = (state_q == WRITE) ? dest[9:0] : lb_addr_q;
  assign bus.lb_data = (state_q == WRITE) ? pix_data  : lb_data_q;

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    k_d     = k_q;
    if (bus.start_row) begin
      state_d = IDLE;
      w_d     = 2'd0;
      k_d     = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.draw_req) begin
            state_d = FETCH;
            w_d     = 2'd0;
          end
        end
        FETCH: state_d = WAIT;
        WAIT: begin
          state_d = WRITE;
          k_d     = 2'd0;
        end
        WRITE: begin
          k_d = k_q + 2'd1;
          if (k_q == 2'd3) begin
            if (w_q == 2'd3) begin
              state_d = IDLE;
              w_d     = 2'd0;
            end else begin
              state_d = FETCH;
              w_d     = w_q + 2'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      w_q     <= 2'd0;
      k_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      k_q     <= k_d;
    end
  end

  // Latched command; start_row discards it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q   <= '0;
      flip_q  <= 1'b0;
      frame_q <= '0;
      row_q   <= '0;
    end else if (bus.start_row) begin
      col_q   <= '0;
      flip_q  <= 1'b0;
      frame_q <= '0;
      row_q   <= '0;
    end else if (accept) begin
      col_q   <= bus.col_base;
      flip_q  <= bus.flip;
      frame_q <= bus.frame_id;
      row_q   <= bus.row_off;
    end
  end

  // ---- stage 1: ROM word captured at the end of WAIT ----
  always_ff @(posedge clk) begin
    if (state_q == WAIT) word_p1 <= bus.rom_data;
  end

  // Line-buffer address/data hold their last WRITE value between writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lb_addr_q <= '0;
      lb_data_q <= '0;
    end else if (state_q == WRITE && !bus.start_row) begin
      lb_addr_q <= dest[9:0];
      lb_data_q <= pix_data;
    end
  end

endmodule

// File: tb/tb_sprite_drawer.sv
`timescale 1ns/1ps

module tb_sprite_drawer;

`ifdef SPRITE_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sprite_drawer_if bus();

  sprite_drawer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [9:0]       col;
    logic             flip;
    logic [7:0]       frame;
    logic [3:0]       row;
    logic [3:0][31:0] words;
    int               exp_cnt;
    logic [13:0]      exp_base;
  } vec_t;

  typedef struct packed {
    logic [9:0] addr;
    logic [7:0] data;
  } wr_t;

  vec_t             vec [5];
  wr_t              exp_q [$];
  wr_t              last_exp;
  logic [3:0][31:0] rom_words;
  int               n_vec = 0;
  int               n_err = 0;
  int               wr_cnt = 0;

  // Pattern ROM: registered read, data one cycle after address.
  always @(posedge clk) bus.rom_data <= rom_words[bus.rom_addr[1:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every line-buffer write must match the next
  // expected write.
  always @(negedge clk) begin
    if (bus.lb_we === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 bus.lb_addr, bus.lb_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("lb_addr", {22'd0, bus.lb_addr}, {22'd0, e.addr});
        chk("lb_data", {24'd0, bus.lb_data}, {24'd0, e.data});
      end
    end
  end

  // Called at posedge+1 of the request cycle; returns at posedge+1 of cycle 1.
  task automatic issue(input vec_t v);
    rom_words = v.words;
    wr_cnt    = 0;
    for (int p = 0; p < 16; p++) begin
      logic [7:0]  d8;
      logic [10:0] dc;
      d8 = v.words[p / 4][8 * (p % 4) +: 8];
      dc = 11'(v.col) + 11'(v.flip ? (15 - p) : p);
      if (d8 != 8'd0 && (!CLIP || dc < 11'd640)) begin
        exp_q.push_back({dc[9:0], d8});
        last_exp = {dc[9:0], d8};
      end
    end
    bus.draw_req = 1'b1;
    bus.col_base = v.col;
    bus.flip     = v.flip;
    bus.frame_id = v.frame;
    bus.row_off  = v.row;
    @(negedge clk);
    chk("draw_done_c0", {31'd0, bus.draw_done}, 32'd0);
    @(posedge clk); #1;
    bus.draw_req = 1'b0;
  endtask

  // Busy cycles 1..24, then optionally the idle checks of cycle 25.
  task automatic track(input vec_t v, input bit end_chk);
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      chk("draw_done_busy", {31'd0, bus.draw_done}, 32'd0);
      if ((c - 1) % 6 == 0)
        chk("rom_addr", {18'd0, bus.rom_addr}, {18'd0, v.exp_base + 14'((c - 1) / 6)});
      @(posedge clk); #1;
    end
    chk("write_count", wr_cnt, v.exp_cnt);
    if (end_chk) begin
      @(negedge clk);
      chk("draw_done_c25", {31'd0, bus.draw_done}, 32'd1);
      chk("queue_empty", exp_q.size(), 32'd0);
      chk("lb_addr_hold", {22'd0, bus.lb_addr}, {22'd0, last_exp.addr});
      chk("lb_data_hold", {24'd0, bus.lb_data}, {24'd0, last_exp.data});
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{col:10'd100, flip:1'b0, frame:8'd5, row:4'd3,
               words:{32'h100F0E0D, 32'h0C0B0A09, 32'h08070605, 32'h04030201},
               exp_cnt:16, exp_base:14'h14C};
    vec[1] = '{col:10'd100, flip:1'b1, frame:8'd5, row:4'd3,
               words:{32'h100F0E0D, 32'h0C0B0A09, 32'h08070605, 32'h04030201},
               exp_cnt:16, exp_base:14'h14C};
    vec[2] = '{col:10'd200, flip:1'b0, frame:8'hA7, row:4'd15,
               words:{32'h090A0B0C, 32'h05060708, 32'h01020304, 32'h00110022},
               exp_cnt:14, exp_base:14'h29FC};
    vec[3] = '{col:10'd630, flip:1'b0, frame:8'd1, row:4'd0,
               words:{32'h100F0E0D, 32'h0C0B0A09, 32'h08070605, 32'h04030201},
               exp_cnt:(CLIP ? 10 : 16), exp_base:14'h040};
    vec[4] = '{col:10'd1020, flip:1'b1, frame:8'hFF, row:4'd7,
               words:{32'h99AABBCC, 32'h00FF0080, 32'h55667788, 32'h11223344},
               exp_cnt:(CLIP ? 0 : 14), exp_base:14'h3FDC};

    reset         = 1'b0;
    bus.start_row = 1'b0;
    bus.draw_req  = 1'b0;
    bus.col_base  = '0;
    bus.flip      = 1'b0;
    bus.frame_id  = '0;
    bus.row_off   = '0;
    rom_words     = '0;
    last_exp      = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_draw_done", {31'd0, bus.draw_done}, 32'd1);
    chk("rst_lb_we",     {31'd0, bus.lb_we},     32'd0);
    chk("rst_lb_addr",   {22'd0, bus.lb_addr},   32'd0);
    chk("rst_lb_data",   {24'd0, bus.lb_data},   32'd0);
    chk("rst_rom_addr",  {18'd0, bus.rom_addr},  32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Table-driven commands.
    for (int i = 0; i < 5; i++) begin
      issue(vec[i]);
      track(vec[i], 1'b1);
    end

    // Back-to-back: second request in the first idle cycle.
    issue(vec[2]);
    track(vec[2], 1'b0);
    issue(vec[0]);
    track(vec[0], 1'b1);

    // Asynchronous reset in the middle of the first word's writes.
    issue(vec[0]);
    exp_q = exp_q[0:0];
    @(posedge clk); #1;          // cycle 2
    @(posedge clk); #1;          // cycle 3: first write
    @(posedge clk); #1;          // cycle 4
    reset = 1'b0;
    @(negedge clk);
    chk("arst_draw_done", {31'd0, bus.draw_done}, 32'd1);
    chk("arst_lb_we",     {31'd0, bus.lb_we},     32'd0);
    chk("arst_lb_addr",   {22'd0, bus.lb_addr},   32'd0);
    chk("arst_lb_data",   {24'd0, bus.lb_data},   32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    last_exp = '0;
    repeat (30) @(posedge clk);
    #1;
    chk("arst_write_count", wr_cnt, 32'd1);
    chk("arst_queue_empty", exp_q.size(), 32'd0);
    chk("arst_idle", {31'd0, bus.draw_done}, 32'd1);

    // start_row during the second FETCH (cycle 7).
    issue(vec[0]);
    exp_q    = exp_q[0:3];
    last_exp = exp_q[3];
    repeat (6) begin
      @(posedge clk); #1;
    end
    bus.start_row = 1'b1;
    @(negedge clk);
    chk("abort_lb_we", {31'd0, bus.lb_we}, 32'd0);
    @(posedge clk); #1;
    bus.start_row = 1'b0;
    @(negedge clk);
    chk("abort_draw_done", {31'd0, bus.draw_done}, 32'd1);
    repeat (30) @(posedge clk);
    #1;
    chk("abort_write_count", wr_cnt, 32'd4);
    chk("abort_queue_empty", exp_q.size(), 32'd0);
    chk("abort_lb_addr_hold", {22'd0, bus.lb_addr}, {22'd0, last_exp.addr});
    chk("abort_lb_data_hold", {24'd0, bus.lb_data}, {24'd0, last_exp.data});

    // draw_req and start_row together: request dropped.
    @(posedge clk); #1;
    wr_cnt        = 0;
    rom_words     = vec[0].words;
    bus.draw_req  = 1'b1;
    bus.start_row = 1'b1;
    bus.col_base  = vec[0].col;
    bus.flip      = vec[0].flip;
    bus.frame_id  = vec[0].frame;
    bus.row_off   = vec[0].row;
    @(negedge clk);
    chk("both_draw_done_c0", {31'd0, bus.draw_done}, 32'd1);
    @(posedge clk); #1;
    bus.draw_req  = 1'b0;
    bus.start_row = 1'b0;
    @(negedge clk);
    chk("both_draw_done_c1", {31'd0, bus.draw_done}, 32'd1);
    repeat (30) @(posedge clk);
    #1;
    chk("both_write_count", wr_cnt, 32'd0);
    chk("both_idle", {31'd0, bus.draw_done}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
